// File: rtl/i2c_req_arbiter.sv
// Round-robin front end that lets NREQ clients share one I2C master push/pop interface.
// Each grant becomes one contiguous push burst (address byte + payload); read bytes are routed back to the owner.
module i2c_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 100000,
    parameter int GW      = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*4-1:0] req_len,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] wr_data,
    output logic [NREQ-1:0]   wr_ack,
    output logic [NREQ-1:0]   rd_valid,
    output logic [7:0]        rd_data,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              busy,
    output logic [GW-1:0]     grant_id,
    input  logic              m_canin,
    output logic              m_pushin,
    output logic [7:0]        m_data_in,
    input  logic              m_pushout,
    input  logic [7:0]        m_data_out
);

    typedef enum logic [2:0] {IDLE, PUSH_ADDR, PUSH_DATA, WAIT_DONE, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [GW-1:0]     grant_reg, grant_next;
    logic [GW-1:0]     last_grant_reg, last_grant_next;
    logic [6:0]        addr_reg, addr_next;
    logic              write_reg, write_next;
    logic [3:0]        len_reg, len_next;
    logic [3:0]        beat_reg, beat_next;
    logic [3:0]        rd_cnt_reg, rd_cnt_next;
    logic              seen_busy_reg, seen_busy_next;
    logic [31:0]       wd_cnt_reg, wd_cnt_next;
    logic [NREQ-1:0]   req_ready_reg, req_ready_next;
    logic [NREQ-1:0]   wr_ack_reg, wr_ack_next;
    logic [NREQ-1:0]   rd_valid_reg, rd_valid_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [NREQ-1:0]   err_reg, err_next;
    logic [7:0]        rd_data_reg, rd_data_next;
    logic              busy_reg, busy_next;
    logic              m_pushin_reg, m_pushin_next;
    logic [7:0]        m_data_in_reg, m_data_in_next;

    logic [6:0]        addr_arr  [NREQ];
    logic [3:0]        len_arr   [NREQ];
    logic [7:0]        wdat_arr  [NREQ];
    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [GW-1:0]     scan_idx;
    logic [NREQ-1:0]   pick_oh, owner_oh;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[7*gi +: 7];
            assign len_arr[gi]  = req_len[4*gi +: 4];
            assign wdat_arr[gi] = wr_data[8*gi +: 8];
            assign pick_oh[gi]  = (pick_idx == GW'(gi));
            assign owner_oh[gi] = (grant_reg == GW'(gi));
        end
    endgenerate

    // Scan starts one past the previous owner so a continuously-valid client cannot starve the rest.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = GW'((int'(last_grant_reg) + off) % NREQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Outputs are computed for the state being entered so they line up with it once registered.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        write_next      = write_reg;
        len_next        = len_reg;
        beat_next       = beat_reg;
        rd_cnt_next     = rd_cnt_reg;
        seen_busy_next  = seen_busy_reg;
        wd_cnt_next     = wd_cnt_reg;
        req_ready_next  = '0;
        wr_ack_next     = '0;
        rd_valid_next   = '0;
        done_next       = '0;
        err_next        = '0;
        rd_data_next    = rd_data_reg;
        m_pushin_next   = 1'b0;
        m_data_in_next  = 8'h00;

        // The master may drop canin while still receiving the burst, so busy is tracked from grant onward.
        if (state_reg != IDLE && !m_canin)
            seen_busy_next = 1'b1;

        case (state_reg)
            IDLE: begin
                if (pick_found && m_canin) begin
                    state_next      = PUSH_ADDR;
                    grant_next      = pick_idx;
                    last_grant_next = pick_idx;
                    addr_next       = addr_arr[pick_idx];
                    write_next      = req_write[pick_idx];
                    len_next        = len_arr[pick_idx];
                    rd_cnt_next     = '0;
                    seen_busy_next  = 1'b0;
                    req_ready_next  = pick_oh;
                    m_pushin_next   = 1'b1;
                    m_data_in_next  = {addr_arr[pick_idx], req_write[pick_idx]};
                    if (req_write[pick_idx] && len_arr[pick_idx] != 4'd0)
                        wr_ack_next = pick_oh;
                end
            end
            PUSH_ADDR: begin
                if (len_reg == 4'd0) begin
                    state_next  = WAIT_DONE;
                    wd_cnt_next = '0;
                end else begin
                    state_next     = PUSH_DATA;
                    beat_next      = 4'd1;
                    m_pushin_next  = 1'b1;
                    m_data_in_next = write_reg ? wdat_arr[grant_reg] : 8'h00;
                    if (write_reg && len_reg > 4'd1)
                        wr_ack_next = owner_oh;
                end
            end
            PUSH_DATA: begin
                if (beat_reg == len_reg) begin
                    state_next  = WAIT_DONE;
                    wd_cnt_next = '0;
                end else begin
                    beat_next      = beat_reg + 4'd1;
                    m_pushin_next  = 1'b1;
                    m_data_in_next = write_reg ? wdat_arr[grant_reg] : 8'h00;
                    if (write_reg && (beat_reg + 4'd1) < len_reg)
                        wr_ack_next = owner_oh;
                end
            end
            WAIT_DONE: begin
                if (m_pushout && !write_reg && rd_cnt_reg < len_reg) begin
                    rd_valid_next = owner_oh;
                    rd_data_next  = m_data_out;
                    rd_cnt_next   = (rd_cnt_reg == 4'd15) ? 4'd15 : rd_cnt_reg + 4'd1;
                end
                if (seen_busy_reg && m_canin && (write_reg || rd_cnt_reg == len_reg)) begin
                    state_next = FINISH;
                    done_next  = owner_oh;
                end else if (wd_cnt_reg == 32'(TIMEOUT - 1)) begin
                    state_next = FINISH;
                    done_next  = owner_oh;
                    err_next   = owner_oh;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 32'd1;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NREQ - 1);
            addr_reg       <= '0;
            write_reg      <= 1'b0;
            len_reg        <= '0;
            beat_reg       <= '0;
            rd_cnt_reg     <= '0;
            seen_busy_reg  <= 1'b0;
            wd_cnt_reg     <= '0;
            req_ready_reg  <= '0;
            wr_ack_reg     <= '0;
            rd_valid_reg   <= '0;
            done_reg       <= '0;
            err_reg        <= '0;
            rd_data_reg    <= '0;
            busy_reg       <= 1'b0;
            m_pushin_reg   <= 1'b0;
            m_data_in_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            write_reg      <= write_next;
            len_reg        <= len_next;
            beat_reg       <= beat_next;
            rd_cnt_reg     <= rd_cnt_next;
            seen_busy_reg  <= seen_busy_next;
            wd_cnt_reg     <= wd_cnt_next;
            req_ready_reg  <= req_ready_next;
            wr_ack_reg     <= wr_ack_next;
            rd_valid_reg   <= rd_valid_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            rd_data_reg    <= rd_data_next;
            busy_reg       <= busy_next;
            m_pushin_reg   <= m_pushin_next;
            m_data_in_reg  <= m_data_in_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign wr_ack    = wr_ack_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign busy      = busy_reg;
    assign grant_id  = grant_reg;
    assign m_pushin  = m_pushin_reg;
    assign m_data_in = m_data_in_reg;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: two requesters, a behavioural I2C master/slave stub,
// expected grants/push bytes/read bytes/completions queued at stimulus time and popped on DUT output.
module tb_i2c_req_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 50;
    localparam int GW   = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*4-1:0] req_len;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] wr_data;
    logic [NREQ-1:0]   wr_ack;
    logic [NREQ-1:0]   rd_valid;
    logic [7:0]        rd_data;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              busy;
    logic [GW-1:0]     grant_id;
    logic              m_canin;
    logic              m_pushin;
    logic [7:0]        m_data_in;
    logic              m_pushout;
    logic [7:0]        m_data_out;

    always #5 clk = ~clk;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_len(req_len),
        .req_ready(req_ready), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .busy(busy), .grant_id(grant_id),
        .m_canin(m_canin), .m_pushin(m_pushin), .m_data_in(m_data_in),
        .m_pushout(m_pushout), .m_data_out(m_data_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard queues
    int          q_grant[$];
    logic [7:0]  q_push[$];
    logic [15:0] q_rd[$];
    logic [15:0] q_done[$];
    int          q_burst[$];

    // requester, slave and stub state
    logic [7:0] pay [NREQ][16];
    int         wr_pos [NREQ];
    logic       prev_ack [NREQ];
    logic       hold_valid [NREQ];
    int         ack_cnt [NREQ];
    int         grant_cnt [NREQ];
    logic [7:0] ref_mem [16];
    logic [7:0] slave_mem [16];
    logic [7:0] mst_buf [17];
    int         mst_state, mst_n, mst_delay, mst_idx, mst_rlen;
    logic       mst_rd;
    logic       no_resp;
    int         cyc, last_push_cyc, done_cyc, burst_len;

    function automatic logic [NREQ-1:0] oh(input int r);
        logic [NREQ-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic service();
        logic [15:0] e;
        cyc++;
        // output monitors
        if (m_pushin) begin
            last_push_cyc = cyc;
            burst_len++;
            if (q_push.size() == 0) check("push_unexp", 32'(m_pushin), 0);
            else check("push_byte", 32'(m_data_in), 32'(q_push.pop_front()));
        end else if (burst_len > 0) begin
            if (q_burst.size() == 0) check("burst_unexp", burst_len, 0);
            else check("burst_len", burst_len, q_burst.pop_front());
            burst_len = 0;
        end
        if (req_ready != '0) begin
            if (q_grant.size() == 0) check("grant_unexp", 32'(req_ready), 0);
            else begin
                int r;
                r = q_grant.pop_front();
                check("grant", 32'(req_ready), 32'(oh(r)));
                check("grant_id", 32'(grant_id), r);
            end
        end
        if (rd_valid != '0) begin
            if (q_rd.size() == 0) check("rd_unexp", 32'(rd_valid), 0);
            else begin
                e = q_rd.pop_front();
                check("rd", {22'b0, rd_valid, rd_data}, {22'b0, oh(int'(e[15:8])), e[7:0]});
            end
        end
        if (done != '0) begin
            done_cyc = cyc;
            if (q_done.size() == 0) check("done_unexp", 32'(done), 0);
            else begin
                e = q_done.pop_front();
                check("done_err", {28'b0, done, err},
                      {28'b0, oh(int'(e[15:8])), e[0] ? oh(int'(e[15:8])) : 2'b00});
            end
        end else if (err != '0) begin
            check("err_wo_done", 32'(err), 0);
        end
        // requester side: advance payload after the byte has been captured
        for (int i = 0; i < NREQ; i++) begin
            if (wr_ack[i]) ack_cnt[i]++;
            if (req_ready[i]) grant_cnt[i]++;
            if (prev_ack[i] && wr_pos[i] < 15) wr_pos[i]++;
            prev_ack[i] = wr_ack[i];
            if (req_ready[i]) begin
                wr_pos[i] = 0;
                if (!hold_valid[i]) req_valid[i] = 1'b0;
            end
            wr_data[8*i +: 8] = pay[i][wr_pos[i]];
        end
        // master + slave stub
        if (rst) begin
            mst_state = 0;
            m_canin   = 1'b1;
            m_pushout = 1'b0;
            for (int i = 0; i < NREQ; i++) prev_ack[i] = 1'b0;
        end else begin
            case (mst_state)
                0: begin
                    m_pushout = 1'b0;
                    if (m_pushin) begin
                        mst_buf[0] = m_data_in;
                        mst_n      = 1;
                        m_canin    = 1'b0;
                        mst_state  = 1;
                    end
                end
                1: begin
                    if (m_pushin) begin
                        if (mst_n < 17) mst_buf[mst_n] = m_data_in;
                        mst_n++;
                    end else begin
                        mst_rd = 1'b0;
                        if (mst_buf[0][7:1] == 7'd25) begin
                            if (mst_buf[0][0])
                                for (int k = 0; k < mst_n - 1 && k < 16; k++) slave_mem[k] = mst_buf[k+1];
                            mst_rd   = !mst_buf[0][0];
                            mst_rlen = mst_n - 1;
                        end
                        mst_delay = 3;
                        mst_state = 2;
                    end
                end
                2: begin
                    mst_delay--;
                    if (mst_delay == 0) begin
                        if (mst_rd && !no_resp) begin
                            mst_state = 3;
                            mst_idx   = 0;
                        end else begin
                            m_canin   = 1'b1;
                            mst_state = 0;
                        end
                    end
                end
                default: begin
                    if (mst_idx < mst_rlen) begin
                        m_pushout  = 1'b1;
                        m_data_out = slave_mem[mst_idx];
                        mst_idx++;
                    end else begin
                        m_pushout = 1'b0;
                        m_canin   = 1'b1;
                        mst_state = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        service();
    endtask

    task automatic drive_req(input int r, input logic wr, input logic [6:0] a, input int n, input logic [7:0] seed);
        for (int k = 0; k < 16; k++) pay[r][k] = seed + 8'(17 * k);
        req_addr[7*r +: 7] = a;
        req_write[r]       = wr;
        req_len[4*r +: 4]  = 4'(n);
        wr_pos[r]          = 0;
        wr_data[8*r +: 8]  = pay[r][0];
        req_valid[r]       = 1'b1;
    endtask

    task automatic expect_txn(input int r, input logic wr, input logic [6:0] a, input int n, input logic tmo);
        q_grant.push_back(r);
        q_push.push_back({a, wr});
        for (int k = 0; k < n; k++) q_push.push_back(wr ? pay[r][k] : 8'h00);
        q_burst.push_back(n + 1);
        if (wr) for (int k = 0; k < n; k++) ref_mem[k] = pay[r][k];
        else if (!tmo) for (int k = 0; k < n; k++) q_rd.push_back({8'(r), ref_mem[k]});
        q_done.push_back({8'(r), 7'b0, tmo});
    endtask

    task automatic issue(input int r, input logic wr, input logic [6:0] a, input int n,
                         input logic [7:0] seed, input logic tmo);
        drive_req(r, wr, a, n, seed);
        expect_txn(r, wr, a, n, tmo);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q_push.size() == 0 && q_grant.size() == 0 && q_done.size() == 0 &&
                q_rd.size() == 0 && q_burst.size() == 0 && !busy && req_valid == '0)
                break;
            step();
        end
        check(tag, q_push.size() + q_grant.size() + q_done.size() + q_rd.size() + q_burst.size()
                   + int'(busy), 0);
    endtask

    initial begin
        int a0, g0, g1, pc;
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_write = '0; req_len = '0; wr_data = '0;
        m_canin = 1'b1; m_pushout = 1'b0; m_data_out = '0; no_resp = 1'b0;
        cyc = 0; last_push_cyc = 0; done_cyc = 0; burst_len = 0;
        mst_state = 0; mst_n = 0; mst_delay = 0; mst_idx = 0; mst_rlen = 0; mst_rd = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wr_pos[i] = 0; prev_ack[i] = 1'b0; hold_valid[i] = 1'b0; ack_cnt[i] = 0; grant_cnt[i] = 0;
            for (int k = 0; k < 16; k++) pay[i][k] = '0;
        end
        for (int k = 0; k < 16; k++) begin ref_mem[k] = '0; slave_mem[k] = '0; end
        for (int k = 0; k < 17; k++) mst_buf[k] = '0;

        repeat (3) step();
        check("reset_out", {3'b0, req_ready, wr_ack, rd_valid, rd_data, done, err, busy, grant_id,
                            m_pushin, m_data_in}, 0);

        // fairness + write bursts: both valid out of reset, req0 must win first
        issue(0, 1'b1, 7'd25, 5, 8'hA0, 1'b0);
        issue(1, 1'b1, 7'd25, 3, 8'hB0, 1'b0);
        step();
        rst = 1'b0;
        wait_quiet("t1_quiet", 400);
        check("t1_acks0", ack_cnt[0], 5);
        check("t1_acks1", ack_cnt[1], 3);

        // read routed to req1
        issue(1, 1'b0, 7'd25, 3, 8'h00, 1'b0);
        wait_quiet("t2_quiet", 300);

        // zero-length write
        a0 = ack_cnt[0];
        issue(0, 1'b1, 7'd25, 0, 8'hC0, 1'b0);
        wait_quiet("t3_quiet", 300);
        check("t3_no_ack", ack_cnt[0] - a0, 0);

        // watchdog: master never returns read bytes
        no_resp = 1'b1;
        issue(0, 1'b0, 7'd25, 2, 8'h00, 1'b1);
        wait_quiet("t4_quiet", 300);
        check("t4_tmo_lat", done_cyc - last_push_cyc, TMO + 1);
        no_resp = 1'b0;
        issue(1, 1'b1, 7'd25, 1, 8'hD0, 1'b0);
        wait_quiet("t4b_quiet", 300);

        // reset on the third push cycle of a len-5 write
        drive_req(0, 1'b1, 7'd25, 5, 8'hE0);
        q_grant.push_back(0);
        q_push.push_back({7'd25, 1'b1});
        q_push.push_back(pay[0][0]);
        q_push.push_back(pay[0][1]);
        q_burst.push_back(3);
        pc = 0;
        for (int i = 0; i < 100 && pc < 3; i++) begin
            step();
            if (m_pushin) pc++;
        end
        check("t5_reach3", pc, 3);
        rst = 1'b1;
        step();
        check("t5_rst_out", {3'b0, req_ready, wr_ack, rd_valid, rd_data, done, err, busy, grant_id,
                             m_pushin, m_data_in}, 0);
        rst = 1'b0;
        issue(0, 1'b1, 7'd25, 2, 8'hF0, 1'b0);
        issue(1, 1'b1, 7'd25, 1, 8'h90, 1'b0);
        wait_quiet("t5_quiet", 400);

        // starvation: req0 held valid, req1 must get the next grant
        hold_valid[0] = 1'b1;
        g0 = grant_cnt[0];
        issue(0, 1'b1, 7'd25, 1, 8'h11, 1'b0);
        for (int i = 0; i < 50 && grant_cnt[0] == g0; i++) step();
        check("t6_g0", grant_cnt[0] - g0, 1);
        g1 = grant_cnt[1];
        issue(1, 1'b1, 7'd25, 2, 8'h22, 1'b0);
        expect_txn(0, 1'b1, 7'd25, 1, 1'b0);
        for (int i = 0; i < 200 && grant_cnt[1] == g1; i++) step();
        check("t6_g1", grant_cnt[1] - g1, 1);
        hold_valid[0] = 1'b0;
        wait_quiet("t6_quiet", 400);
        check("t6_g0_total", grant_cnt[0] - g0, 2);

        for (int k = 0; k < 5; k++) check($sformatf("mem%0d", k), 32'(slave_mem[k]), 32'(ref_mem[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
